// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring
// divide on operand magnitudes, with sign fix-up and register-file write-back.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  write_addr,
  output logic        write_en
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        fin_ph;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [63:0] prod;   // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
  logic [31:0] opb;    // mul: multiplicand magnitude; div: divisor magnitude
  logic        neg_p, neg_q, neg_r;
  logic [31:0] res_fix;

  // operand signedness and magnitudes from the request
  logic        signed_a, signed_b, na, nb;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    signed_a = func3[2] ? ~func3[0] : ~(func3[1] & func3[0]);
    signed_b = func3[2] ? ~func3[0] : ~func3[1];
    na       = signed_a & data_1[31];
    nb       = signed_b & data_2[31];
    mag_a    = na ? (~data_1 + 32'd1) : data_1;
    mag_b    = nb ? (~data_2 + 32'd1) : data_2;
  end

  // one iteration of each datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opb} : 33'd0);
    mul_next = {mul_sum, prod[31:1]};
    div_sh   = {prod[63:32], prod[31]};
    div_ge   = div_sh >= {1'b0, opb};
    div_rem  = div_sh[31:0] - opb;
    div_next = div_ge ? {div_rem, prod[30:0], 1'b1}
                      : {div_sh[31:0], prod[30:0], 1'b0};
  end

  // sign correction and result select
  logic [63:0] prod_s;
  logic [31:0] q_s, r_s, sel;

  always_comb begin
    prod_s = neg_p ? (~prod + 64'd1) : prod;
    q_s    = neg_q ? (~prod[31:0] + 32'd1) : prod[31:0];
    r_s    = neg_r ? (~prod[63:32] + 32'd1) : prod[63:32];
    case (op)
      3'b000:                 sel = prod_s[31:0];
      3'b001, 3'b010, 3'b011: sel = prod_s[63:32];
      3'b100, 3'b101:         sel = q_s;
      default:                sel = r_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      fin_ph     <= 1'b0;
      op         <= 3'd0;
      rd_q       <= 5'd0;
      prod       <= 64'd0;
      opb        <= 32'd0;
      neg_p      <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      res_fix    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 32'd0;
      write_addr <= 5'd0;
      write_en   <= 1'b0;
    end else begin
      done     <= 1'b0;
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op     <= func3;
            rd_q   <= rd_addr;
            cnt    <= 5'd0;
            busy   <= 1'b1;
            neg_p  <= na ^ nb;
            // divide-by-zero keeps the all-ones quotient unsigned-looking
            neg_q  <= (na ^ nb) & (data_2 != 32'd0);
            neg_r  <= na;
            if (func3[2]) begin
              state <= DIV;
              prod  <= {32'd0, mag_a};
              opb   <= mag_b;
            end else begin
              state <= MUL;
              prod  <= {32'd0, mag_b};
              opb   <= mag_a;
            end
          end
        end
        MUL, DIV: begin
          prod <= (state == MUL) ? mul_next : div_next;
          if (cnt == 5'd31) begin
            state  <= FIN;
            fin_ph <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        FIN: begin
          if (!fin_ph) begin
            res_fix <= sel;
            fin_ph  <= 1'b1;
          end else begin
            result     <= res_fix;
            write_addr <= rd_q;
            write_en   <= (rd_q != 5'd0);
            done       <= 1'b1;
            busy       <= 1'b0;
            fin_ph     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: RV32M results, corner cases, latency,
// reset abort, busy-start rejection and back-to-back issue.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] data_1, data_2;
  logic [4:0]  rd_addr;
  logic        busy, done, write_en;
  logic [31:0] result;
  logic [4:0]  write_addr;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .data_1(data_1), .data_2(data_2), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result),
    .write_addr(write_addr), .write_en(write_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from an off-edge time; returns edges from accept to DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int n);
    func3 = f; data_1 = a; data_2 = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1 n++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    run_op(f, a, b, 5'd1, n);
    chk({tag, "_lat"}, n, 32'd34);
    chk(tag, result, exp);
  endtask

  initial begin
    int n, dn;
    rst = 1'b1; start = 1'b0; func3 = 3'd0; data_1 = 32'd0; data_2 = 32'd0; rd_addr = 5'd0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_waddr", {27'd0, write_addr}, 32'd0);
    chk("rst_we", {31'd0, write_en}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, n);
    chk("mul_lat", n, 32'd34);
    chk("mul_res", result, 32'hFFFFFFEB);
    chk("mul_waddr", {27'd0, write_addr}, 32'd5);
    chk("mul_we", {31'd0, write_en}, 32'd1);
    chk("mul_busy_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("mul_done_pulse", {31'd0, done}, 32'd0);
    chk("mul_we_pulse", {31'd0, write_en}, 32'd0);
    chk("mul_res_hold", result, 32'hFFFFFFEB);

    op_chk("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op_chk("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    op_chk("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    op_chk("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    op_chk("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    op_chk("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    op_chk("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    op_chk("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF);
    op_chk("remu_z", 3'b111, 32'd5, 32'd0, 32'd5);
    op_chk("div_z_neg", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
    op_chk("rem_z_neg", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    op_chk("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    op_chk("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    op_chk("mul_lo_neg", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);

    run_op(3'b000, 32'd3, 32'd4, 5'd0, n);
    chk("x0_lat", n, 32'd34);
    chk("x0_done", {31'd0, done}, 32'd1);
    chk("x0_res", result, 32'd12);
    chk("x0_we", {31'd0, write_en}, 32'd0);
    run_op(3'b000, 32'd5, 32'd6, 5'd3, n);
    chk("b2b_lat", n, 32'd34);
    chk("b2b_res", result, 32'd30);
    chk("b2b_we", {31'd0, write_en}, 32'd1);

    // reset during iteration 10
    func3 = 3'b000; data_1 = 32'd9; data_2 = 32'd9; rd_addr = 5'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_waddr", {27'd0, write_addr}, 32'd0);
    chk("abort_we", {31'd0, write_en}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(3'b101, 32'd100, 32'd7, 5'd4, n);
    chk("post_rst_lat", n, 32'd34);
    chk("post_rst_res", result, 32'd14);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1 if (done === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 32'd0);

    // START while busy must be dropped
    func3 = 3'b011; data_1 = 32'hFFFFFFFF; data_2 = 32'hFFFFFFFF; rd_addr = 5'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1 n++;
      if (n == 5) begin
        func3 = 3'b101; data_1 = 32'd1; data_2 = 32'd1; rd_addr = 5'd10; start = 1'b1;
      end
      if (n == 8) start = 1'b0;
    end
    chk("busy_start_lat", n, 32'd34);
    chk("busy_start_res", result, 32'hFFFFFFFE);
    chk("busy_start_waddr", {27'd0, write_addr}, 32'd9);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1 if (done === 1'b1) dn++;
    end
    chk("busy_start_no_queue", dn, 32'd0);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset; clears all state immediately.
REQ-004 START  input  1  request; sampled only when BUSY=0.
REQ-005 FUNC3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 DATA_1  input  32  rs1 operand from register-file read port 1 (multiplicand or dividend).
REQ-007 DATA_2  input  32  rs2 operand from register-file read port 2 (multiplier or divisor).
REQ-008 RD_ADDR  input  5  destination register index.
REQ-009 BUSY  output  1  high while an operation is in flight; upstream stalls on it.
REQ-010 DONE  output  1  one-cycle completion pulse.
REQ-011 RESULT  output  32  result; drives register-file WRITE_DATA.
REQ-012 WRITE_ADDR  output  5  captured RD_ADDR; drives register-file WRITE_ADDR.
REQ-013 WRITE_EN  output  1  register-file write enable; equals DONE AND (WRITE_ADDR != 0).

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV and FIN; decode FUNC3[2] selects MUL (0) or DIV (1).
REQ-015 IDLE: on a rising edge with START=1, SHALL capture FUNC3, DATA_1, DATA_2 and RD_ADDR, load a 5-bit iteration counter with 0, and enter MUL or DIV.
REQ-016 MUL: SHALL perform radix-2 shift-add on 32-bit operand magnitudes with a 64-bit product, one bit per cycle, for exactly 32 cycles.
REQ-017 DIV: SHALL perform restoring division on 32-bit magnitudes, one quotient bit per cycle, for exactly 32 cycles.
REQ-018 The counter SHALL move the FSM to FIN after iteration 31, with no wrap beyond 31.
REQ-019 Sign handling: operands are signed for MUL/MULH/DIV/REM; rs1 signed and rs2 unsigned for MULHSU; otherwise unsigned; the result SHALL be negated in FIN when required.
REQ-020 Result select: MUL uses product[31:0]; MULH/MULHSU/MULHU use product[63:32]; DIV/DIVU use the quotient; REM/REMU use the remainder.
REQ-021 Remainder sign SHALL follow the dividend; quotient sign SHALL be the XOR of operand signs.
REQ-022 Divide by zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL equal the dividend, with unchanged latency.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0, with unchanged latency.
REQ-024 FIN: SHALL register RESULT, assert DONE for one cycle, and return to IDLE; RESULT and WRITE_ADDR SHALL hold until the next DONE.
REQ-025 Latency: DONE SHALL be high in the cycle following the 34th rising edge after the START-sampling edge, for every opcode.
REQ-026 BUSY SHALL be high in MUL, DIV and FIN, and low only in IDLE.
REQ-027 START while BUSY=1 SHALL be ignored; no queuing.
REQ-028 Back-to-back: START high in the cycle after DONE SHALL be accepted with no bubble beyond IDLE.
REQ-029 RD_ADDR=0 SHALL complete normally with DONE=1 but WRITE_EN=0, protecting x0.
REQ-030 WRITE_EN SHALL be registered so it is stable before the register file's falling-edge write.

Reset
REQ-031 RESET=1 SHALL force state IDLE, counter 0, and BUSY, DONE, WRITE_EN, RESULT and WRITE_ADDR to 0, asynchronously.
REQ-032 RESET mid-operation SHALL abort the operation with no DONE and no write; START is accepted on the first rising edge after RESET falls.

Verification
REQ-033 MUL 7 x 0xFFFFFFFD, RD=5 -> DONE after 34 edges, RESULT=0xFFFFFFEB, WRITE_ADDR=5, WRITE_EN=1 for one cycle.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-035 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-036 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-037 RESET pulsed at iteration 10 -> all outputs 0 immediately, no DONE; START during BUSY -> ignored, first result unchanged.
REQ-038 RD=0 MUL 3 x 4 -> DONE=1, RESULT=12, WRITE_EN=0; immediate back-to-back START accepted, second DONE 34 edges later.
